// File: rtl/niu32_pkg.sv
// Shared Niu32 constants: word size and the I/O page register map.
// Used by the core, the data-memory decode and the I/O responder.
package niu32_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [WORD_SIZE-1:0] ADDR_HEX     = 32'hFFFF0000;
    localparam logic [WORD_SIZE-1:0] ADDR_LEDR    = 32'hFFFF0020;
    localparam logic [WORD_SIZE-1:0] ADDR_LEDG    = 32'hFFFF0040;
    localparam logic [WORD_SIZE-1:0] ADDR_KEY     = 32'hFFFF0100;
    localparam logic [WORD_SIZE-1:0] ADDR_KEYEDGE = 32'hFFFF0104;
    localparam logic [WORD_SIZE-1:0] ADDR_SWITCH  = 32'hFFFF0120;

    function automatic logic is_io_page(input logic [WORD_SIZE-1:0] addr);
        return addr[31:16] == 16'hFFFF;
    endfunction

endpackage

// File: rtl/niu32_io_responder_if.sv
// Memory-stage request/response bus between the core (master) and the
// I/O responder (slave).
interface niu32_io_responder_if;
    import niu32_pkg::*;

    logic                 req_valid;
    logic                 req_we;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 io_hit;
    logic                 resp_ready;
    logic [WORD_SIZE-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  io_hit, resp_ready, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output io_hit, resp_ready, resp_rdata
    );

endinterface

// File: rtl/niu32_debounce.sv
// One key: 2-flop synchronizer, inversion to pressed-high, and a stability
// counter that must reach DEBOUNCE_CYCLES-1 before the debounced level moves.
module niu32_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    output logic o_db,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             w_pressed;
    logic             w_done;

    assign w_pressed = ~r_sync;
    assign w_done    = (w_pressed != r_db) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_meta <= i_key_n;
            r_sync <= r_meta;
            // Any sample agreeing with the debounced level restarts the count.
            if (w_pressed == r_db) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt <= '0;
                r_db  <= w_pressed;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_db   = r_db;
    assign o_rise = w_done & w_pressed;

endmodule

// File: rtl/niu32_io_responder.sv
// I/O-page responder: HEX/LEDR/LEDG output registers, synchronized switches,
// debounced keys and a sticky read-to-clear key-press register.
module niu32_io_responder
    import niu32_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    niu32_io_responder_if.slave  bus,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SWITCH,
    output logic [9:0]           LEDR,
    output logic [7:0]           LEDG,
    output logic [15:0]          hex_value
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_hit;
    logic                 w_accept;
    logic                 w_resp;
    logic [WORD_SIZE-1:0] w_rdata;
    logic                 w_edge_clr;

    logic [15:0]          r_hex;
    logic [9:0]           r_ledr;
    logic [7:0]           r_ledg;
    logic [WORD_SIZE-1:0] r_rdata;
    logic [3:0]           r_edge;
    logic [9:0]           r_sw_meta;
    logic [9:0]           r_sw_sync;
    logic [3:0]           w_key_db;
    logic [3:0]           w_key_rise;

    assign w_hit      = is_io_page(bus.req_addr);
    assign bus.io_hit = w_hit;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.req_valid && w_hit) w_state_next = S_RESP;
            S_RESP: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_resp   = 1'b0;
        case (r_state)
            S_IDLE: w_accept = bus.req_valid && w_hit;
            S_RESP: w_resp   = 1'b1;
            default: ;
        endcase
    end

    assign bus.resp_ready = w_resp;
    assign bus.resp_rdata = r_rdata;

    for (genvar k = 0; k < 4; k++) begin : g_key
        niu32_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_key_n (KEY[k]),
            .o_db    (w_key_db[k]),
            .o_rise  (w_key_rise[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= SWITCH;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.req_addr)
            ADDR_HEX:     w_rdata = {16'b0, r_hex};
            ADDR_LEDR:    w_rdata = {22'b0, r_ledr};
            ADDR_LEDG:    w_rdata = {24'b0, r_ledg};
            ADDR_KEY:     w_rdata = {28'b0, w_key_db};
            ADDR_KEYEDGE: w_rdata = {28'b0, r_edge};
            ADDR_SWITCH:  w_rdata = {22'b0, r_sw_sync};
            default:      w_rdata = '0;
        endcase
    end

    assign w_edge_clr = w_accept && !bus.req_we && (bus.req_addr == ADDR_KEYEDGE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex   <= '0;
            r_ledr  <= '0;
            r_ledg  <= '0;
            r_rdata <= '0;
            r_edge  <= '0;
        end else begin
            // A new press in the clearing cycle survives the clear.
            r_edge <= (w_edge_clr ? 4'b0 : r_edge) | w_key_rise;
            if (w_accept) begin
                if (bus.req_we) begin
                    r_rdata <= '0;
                    case (bus.req_addr)
                        ADDR_HEX:  r_hex  <= bus.req_wdata[15:0];
                        ADDR_LEDR: r_ledr <= bus.req_wdata[9:0];
                        ADDR_LEDG: r_ledg <= bus.req_wdata[7:0];
                        default: ;
                    endcase
                end else begin
                    r_rdata <= w_rdata;
                end
            end
        end
    end

    assign LEDR      = r_ledr;
    assign LEDG      = r_ledg;
    assign hex_value = r_hex;

endmodule

// File: tb/tb_niu32_io_responder.sv
// Directed bench for niu32_io_responder with an 8-cycle debounce window.
module tb_niu32_io_responder;
    import niu32_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  KEY;
    logic [9:0]  SWITCH;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;
    logic [15:0] hex_value;

    int n_cmp;
    int n_fail;

    niu32_io_responder_if bus ();

    niu32_io_responder #(.DEBOUNCE_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .KEY       (KEY),
        .SWITCH    (SWITCH),
        .LEDR      (LEDR),
        .LEDG      (LEDG),
        .hex_value (hex_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] rd;
        logic [15:0] hex;
        logic [9:0]  ledr;
        logic [7:0]  ledg;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after an edge; accept happens at the next edge.
    // Samples the response cycle and confirms resp_ready drops after it.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic got,
                          output logic [15:0] hex_s, output logic [9:0] ledr_s,
                          output logic [7:0] ledg_s);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick(1);
        got    = bus.resp_ready;
        rd     = bus.resp_rdata;
        hex_s  = hex_value;
        ledr_s = LEDR;
        ledg_s = LEDG;
        bus.req_valid = 1'b0;
        tick(1);
        check("resp_one_cycle", {31'b0, bus.resp_ready}, 32'h0);
    endtask

    task automatic load(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        got;
        logic [15:0] h;
        logic [9:0]  r;
        logic [7:0]  g;
        do_req(1'b0, addr, 32'h0, rd, got, h, r, g);
        check({name, "_ack"}, {31'b0, got}, 32'h1);
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        got;
        logic [15:0] h;
        logic [9:0]  r;
        logic [7:0]  g;
        logic        seen;

        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        KEY    = 4'hF;
        SWITCH = 10'h2A5;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;

        vecs[0]  = '{1'b0, ADDR_KEY,      32'h0,        1'b1, 32'h00000000, 16'h0000, 10'h000, 8'h00};
        vecs[1]  = '{1'b1, ADDR_HEX,      32'hDEADBEEF, 1'b0, 32'h0,        16'hBEEF, 10'h000, 8'h00};
        vecs[2]  = '{1'b0, ADDR_HEX,      32'h0,        1'b1, 32'h0000BEEF, 16'hBEEF, 10'h000, 8'h00};
        vecs[3]  = '{1'b1, ADDR_LEDG,     32'h123456EF, 1'b0, 32'h0,        16'hBEEF, 10'h000, 8'hEF};
        vecs[4]  = '{1'b1, ADDR_LEDR,     32'hFFFFFFFF, 1'b0, 32'h0,        16'hBEEF, 10'h3FF, 8'hEF};
        vecs[5]  = '{1'b0, ADDR_LEDR,     32'h0,        1'b1, 32'h000003FF, 16'hBEEF, 10'h3FF, 8'hEF};
        vecs[6]  = '{1'b0, ADDR_LEDG,     32'h0,        1'b1, 32'h000000EF, 16'hBEEF, 10'h3FF, 8'hEF};
        vecs[7]  = '{1'b0, ADDR_SWITCH,   32'h0,        1'b1, 32'h000002A5, 16'hBEEF, 10'h3FF, 8'hEF};
        vecs[8]  = '{1'b1, ADDR_SWITCH,   32'h00000000, 1'b0, 32'h0,        16'hBEEF, 10'h3FF, 8'hEF};
        vecs[9]  = '{1'b0, ADDR_SWITCH,   32'h0,        1'b1, 32'h000002A5, 16'hBEEF, 10'h3FF, 8'hEF};
        vecs[10] = '{1'b0, 32'hFFFF0200,  32'h0,        1'b1, 32'h00000000, 16'hBEEF, 10'h3FF, 8'hEF};
        vecs[11] = '{1'b1, 32'hFFFF0200,  32'hFFFFFFFF, 1'b0, 32'h0,        16'hBEEF, 10'h3FF, 8'hEF};
        vecs[12] = '{1'b0, ADDR_KEYEDGE,  32'h0,        1'b1, 32'h00000000, 16'hBEEF, 10'h3FF, 8'hEF};
        vecs[13] = '{1'b1, ADDR_HEX,      32'h00001234, 1'b0, 32'h0,        16'h1234, 10'h3FF, 8'hEF};
        vecs[14] = '{1'b0, ADDR_HEX,      32'h0,        1'b1, 32'h00001234, 16'h1234, 10'h3FF, 8'hEF};

        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_ledr", {22'b0, LEDR}, 32'h0);
        check("rst_ledg", {24'b0, LEDG}, 32'h0);
        check("rst_hex", {16'b0, hex_value}, 32'h0);
        check("rst_resp_ready", {31'b0, bus.resp_ready}, 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        tick(2);

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, got, h, r, g);
            check($sformatf("v%0d_ack", i), {31'b0, got}, 32'h1);
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
            check($sformatf("v%0d_hex", i), {16'b0, h}, {16'b0, vecs[i].hex});
            check($sformatf("v%0d_ledr", i), {22'b0, r}, {22'b0, vecs[i].ledr});
            check($sformatf("v%0d_ledg", i), {24'b0, g}, {24'b0, vecs[i].ledg});
        end

        // Non-I/O address: ignored entirely.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h00000100;
        #1;
        check("miss_io_hit", {31'b0, bus.io_hit}, 32'h0);
        seen = 1'b0;
        repeat (4) begin
            tick(1);
            seen = seen | bus.resp_ready;
        end
        check("miss_no_resp", {31'b0, seen}, 32'h0);
        bus.req_addr = ADDR_LEDR;
        #1;
        check("hit_io_hit", {31'b0, bus.io_hit}, 32'h1);
        bus.req_valid = 1'b0;
        tick(1);

        // Reset during the RESP cycle of an LEDR store.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = ADDR_LEDR;
        bus.req_wdata = 32'h00000155;
        tick(1);
        check("rstresp_ack", {31'b0, bus.resp_ready}, 32'h1);
        check("rstresp_ledr_committed", {22'b0, LEDR}, 32'h155);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        tick(1);
        check("rstresp_ready_low", {31'b0, bus.resp_ready}, 32'h0);
        check("rstresp_ledr", {22'b0, LEDR}, 32'h0);
        check("rstresp_hex", {16'b0, hex_value}, 32'h0);
        reset = 1'b0;
        tick(1);
        load("post_rst_ledr", ADDR_LEDR, 32'h0);
        do_req(1'b1, ADDR_LEDR, 32'h000002AA, rd, got, h, r, g);
        check("post_rst_store_ack", {31'b0, got}, 32'h1);
        check("post_rst_store_ledr", {22'b0, r}, 32'h2AA);
        tick(4);

        // KEY[2] bounce: 3-cycle pulses never reach the 8-cycle window.
        repeat (3) begin
            KEY = 4'hB;
            tick(3);
            KEY = 4'hF;
            tick(3);
        end
        tick(12);
        load("bounce_key", ADDR_KEY, 32'h0);
        load("bounce_edge", ADDR_KEYEDGE, 32'h0);

        // KEY[2] held low.
        KEY = 4'hB;
        tick(12);
        load("held_key", ADDR_KEY, 32'h4);
        load("held_edge", ADDR_KEYEDGE, 32'h4);
        load("held_edge_cleared", ADDR_KEYEDGE, 32'h0);
        KEY = 4'hF;
        tick(14);
        load("release_key", ADDR_KEY, 32'h0);
        load("release_no_edge", ADDR_KEYEDGE, 32'h0);

        // KEY[1] press lands exactly on the KEYEDGE read-clear edge (2+8 edges).
        KEY = 4'hD;
        tick(9);
        load("collide_old", ADDR_KEYEDGE, 32'h0);
        load("collide_set", ADDR_KEYEDGE, 32'h2);
        load("collide_clear", ADDR_KEYEDGE, 32'h0);
        load("collide_key", ADDR_KEY, 32'h2);
        KEY = 4'hF;
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
